// File: rtl/wb_tlc_rx_pkt_fifo.sv
// Store-and-forward RX TLP buffer: only complete TLPs reach the consumer.
// TLPs that do not fit, or that are cut short by a new start, are discarded whole.
module wb_tlc_rx_pkt_fifo #(
  parameter int c_DATA_WIDTH = 64,
  parameter int c_ADDR_WIDTH = 9
) (
  input  logic                    clk_125,
  input  logic                    rstn,
  input  logic [c_DATA_WIDTH-1:0] rx_data,
  input  logic                    rx_st,
  input  logic                    rx_end,
  input  logic                    rx_dwen,
  input  logic                    rx_val,
  output logic [c_DATA_WIDTH-1:0] dout,
  output logic                    dout_sop,
  output logic                    dout_eop,
  output logic                    dout_dwen,
  output logic                    dout_val,
  input  logic                    dout_rdy,
  output logic [c_ADDR_WIDTH:0]   pkt_cnt,
  output logic [15:0]             drop_cnt,
  output logic                    drop_pulse
);

  // state | meaning
  // IDLE  | between TLPs, waiting for rx_st
  // PKT   | storing words of an uncommitted TLP
  // DROP  | discarding the rest of a rejected TLP
  typedef enum logic [1:0] {IDLE, PKT, DROP} wr_state_t;

  localparam int DEPTH = 1 << c_ADDR_WIDTH;
  localparam int MW    = c_DATA_WIDTH + 3;
  localparam logic [c_ADDR_WIDTH:0] PTR_ONE  = (c_ADDR_WIDTH+1)'(1);
  localparam logic [c_ADDR_WIDTH:0] FULL_OCC = (c_ADDR_WIDTH+1)'(DEPTH);

  logic [MW-1:0] mem [DEPTH];

  wr_state_t state, state_nxt;
  logic [c_ADDR_WIDTH:0] wr_ptr, wr_ptr_nxt, wr_cmt, wr_cmt_nxt;
  logic [c_ADDR_WIDTH:0] rd_ptr, rd_addr, occ_ptr, occ_cmt;
  logic [c_ADDR_WIDTH-1:0] wr_addr;
  logic                  wr_en, commit;
  logic [1:0]            drop_n;
  logic [16:0]           drop_sum;

  logic [MW-1:0] mid_word, out_word;
  logic          mid_val, out_val;
  logic          xfer, load_out, rd_en, eop_xfer;

  // rd_ptr only moves when the consumer takes a word, so prefetched words still hold their slot
  assign occ_ptr = wr_ptr - rd_ptr;
  assign occ_cmt = wr_cmt - rd_ptr;

  always_comb begin
    state_nxt  = state;
    wr_ptr_nxt = wr_ptr;
    wr_cmt_nxt = wr_cmt;
    wr_en      = 1'b0;
    wr_addr    = wr_ptr[c_ADDR_WIDTH-1:0];
    commit     = 1'b0;
    drop_n     = 2'd0;
    if (rx_val) begin
      if (rx_st) begin
        // a start always restarts from the committed pointer, abandoning any open TLP
        if (state == PKT) drop_n = 2'd1;
        if (occ_cmt == FULL_OCC) begin
          drop_n     = drop_n + 2'd1;
          wr_ptr_nxt = wr_cmt;
          state_nxt  = rx_end ? IDLE : DROP;
        end else begin
          wr_en      = 1'b1;
          wr_addr    = wr_cmt[c_ADDR_WIDTH-1:0];
          wr_ptr_nxt = wr_cmt + PTR_ONE;
          if (rx_end) begin
            wr_cmt_nxt = wr_cmt + PTR_ONE;
            commit     = 1'b1;
            state_nxt  = IDLE;
          end else begin
            state_nxt  = PKT;
          end
        end
      end else if (state == PKT) begin
        if (occ_ptr == FULL_OCC) begin
          drop_n     = 2'd1;
          wr_ptr_nxt = wr_cmt;
          state_nxt  = rx_end ? IDLE : DROP;
        end else begin
          wr_en      = 1'b1;
          wr_ptr_nxt = wr_ptr + PTR_ONE;
          if (rx_end) begin
            wr_cmt_nxt = wr_ptr + PTR_ONE;
            commit     = 1'b1;
            state_nxt  = IDLE;
          end
        end
      end else if (state == DROP && rx_end) begin
        state_nxt = IDLE;
      end
    end
  end

  always_ff @(posedge clk_125) begin
    if (wr_en) mem[wr_addr] <= {rx_dwen, rx_st, rx_end, rx_data};
  end

  // two-stage read: registered memory output, then the FWFT output register
  assign xfer     = out_val & dout_rdy;
  assign load_out = mid_val & (~out_val | xfer);
  assign rd_en    = (rd_addr != wr_cmt) & (~mid_val | load_out);
  assign eop_xfer = xfer & out_word[c_DATA_WIDTH];
  assign drop_sum = {1'b0, drop_cnt} + 17'(drop_n);

  always_ff @(posedge clk_125) begin
    if (rd_en) mid_word <= mem[rd_addr[c_ADDR_WIDTH-1:0]];
  end

  always_ff @(posedge clk_125) begin
    if (!rstn) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      wr_cmt     <= '0;
      rd_ptr     <= '0;
      rd_addr    <= '0;
      mid_val    <= 1'b0;
      out_val    <= 1'b0;
      out_word   <= '0;
      pkt_cnt    <= '0;
      drop_cnt   <= '0;
      drop_pulse <= 1'b0;
    end else begin
      state  <= state_nxt;
      wr_ptr <= wr_ptr_nxt;
      wr_cmt <= wr_cmt_nxt;
      if (xfer) rd_ptr <= rd_ptr + PTR_ONE;
      if (rd_en) begin
        rd_addr <= rd_addr + PTR_ONE;
        mid_val <= 1'b1;
      end else if (load_out) begin
        mid_val <= 1'b0;
      end
      if (load_out) begin
        out_word <= mid_word;
        out_val  <= 1'b1;
      end else if (xfer) begin
        out_val  <= 1'b0;
      end
      case ({commit, eop_xfer})
        2'b10:   pkt_cnt <= pkt_cnt + PTR_ONE;
        2'b01:   pkt_cnt <= pkt_cnt - PTR_ONE;
        default: pkt_cnt <= pkt_cnt;
      endcase
      drop_cnt   <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      drop_pulse <= (drop_n != 2'd0);
    end
  end

  assign dout      = out_word[c_DATA_WIDTH-1:0];
  assign dout_eop  = out_word[c_DATA_WIDTH];
  assign dout_sop  = out_word[c_DATA_WIDTH+1];
  assign dout_dwen = out_word[c_DATA_WIDTH+2];
  assign dout_val  = out_val;

endmodule

// File: tb/tb_wb_tlc_rx_pkt_fifo.sv
// Bench for wb_tlc_rx_pkt_fifo: scoreboard of expected output words plus per-scenario checks.
module tb_wb_tlc_rx_pkt_fifo;

  logic        clk_125 = 1'b0;
  logic        rstn;
  logic [63:0] rx_data;
  logic        rx_st, rx_end, rx_dwen, rx_val;
  logic [63:0] dout;
  logic        dout_sop, dout_eop, dout_dwen, dout_val, dout_rdy;
  logic [9:0]  pkt_cnt;
  logic [15:0] drop_cnt;
  logic        drop_pulse;

  int tests = 0;
  int fails = 0;
  int pulse_cnt = 0;
  logic [66:0] sb [$];

  wb_tlc_rx_pkt_fifo #(.c_DATA_WIDTH(64), .c_ADDR_WIDTH(9)) dut (
    .clk_125(clk_125), .rstn(rstn),
    .rx_data(rx_data), .rx_st(rx_st), .rx_end(rx_end), .rx_dwen(rx_dwen), .rx_val(rx_val),
    .dout(dout), .dout_sop(dout_sop), .dout_eop(dout_eop), .dout_dwen(dout_dwen),
    .dout_val(dout_val), .dout_rdy(dout_rdy),
    .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt), .drop_pulse(drop_pulse)
  );

  always #5 clk_125 = ~clk_125;

  // output monitor: sampled mid-cycle, a word is consumed at the next rising edge
  initial begin
    logic        hold_prev;
    logic [66:0] prev_word, got, exp;
    hold_prev = 1'b0;
    prev_word = '0;
    forever begin
      @(negedge clk_125);
      got = {dout_dwen, dout_sop, dout_eop, dout};
      if (rstn === 1'b1) begin
        if (hold_prev) begin
          tests++;
          if (dout_val !== 1'b1 || got !== prev_word) begin
            fails++;
            $display("FAIL stall_hold: val=%b word=%h, want val=1 word=%h", dout_val, got, prev_word);
          end
        end
        if (dout_val === 1'b1 && dout_rdy === 1'b1) begin
          tests++;
          if (sb.size() == 0) begin
            fails++;
            $display("FAIL sb_extra: got word %h, want none", got);
          end else begin
            exp = sb.pop_front();
            if (got !== exp) begin
              fails++;
              $display("FAIL sb_word: got %h, want %h", got, exp);
            end
          end
        end
        if (drop_pulse === 1'b1) pulse_cnt++;
        hold_prev = (dout_val === 1'b1) && (dout_rdy !== 1'b1);
        prev_word = got;
      end else begin
        hold_prev = 1'b0;
      end
    end
  end

  task automatic rx_word(input logic st, input logic en, input logic dw, input logic [63:0] d);
    rx_val = 1'b1; rx_st = st; rx_end = en; rx_dwen = dw; rx_data = d;
    @(posedge clk_125); #2;
    rx_val = 1'b0; rx_st = 1'b0; rx_end = 1'b0; rx_dwen = 1'b0;
  endtask

  task automatic rx_idle(input int n);
    rx_val = 1'b0;
    repeat (n) begin @(posedge clk_125); #2; end
  endtask

  task automatic send_pkt(input int len, input logic [63:0] base, input logic expect_out);
    for (int i = 0; i < len; i++) begin
      if (expect_out) sb.push_back({1'b0, (i == 0), (i == len-1), base + 64'(i)});
      rx_word(i == 0, i == len-1, 1'b0, base + 64'(i));
    end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((sb.size() != 0 || dout_val !== 1'b0) && n < budget) begin
      @(posedge clk_125); #2;
      n++;
    end
    tests++;
    if (sb.size() != 0 || dout_val !== 1'b0) begin
      fails++;
      $display("FAIL drain: %0d words pending, dout_val=%b, want 0 and 0", sb.size(), dout_val);
    end
  endtask

  task automatic test_reset;
    rstn = 1'b0; rx_val = 1'b0; rx_st = 1'b0; rx_end = 1'b0; rx_dwen = 1'b0;
    rx_data = '0; dout_rdy = 1'b0;
    repeat (3) @(posedge clk_125);
    #2;
    tests++;
    if ({dout_val, dout_sop, dout_eop, dout_dwen, dout, pkt_cnt, drop_cnt, drop_pulse} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: val=%b dout=%h pkt=%0d drop=%0d pulse=%b, want all 0",
               dout_val, dout, pkt_cnt, drop_cnt, drop_pulse);
    end
    rstn = 1'b1;
    rx_idle(1);
  endtask

  task automatic test_latency;
    dout_rdy = 1'b1;
    send_pkt(4, 64'hA000_0000_0000_0000, 1'b1);
    tests++;
    if (pkt_cnt !== 10'd1 || dout_val !== 1'b0) begin
      fails++;
      $display("FAIL lat_commit: pkt_cnt=%0d val=%b, want 1 and 0", pkt_cnt, dout_val);
    end
    rx_idle(1);
    tests++;
    if (dout_val !== 1'b0) begin
      fails++;
      $display("FAIL lat_early: dout_val=%b one edge after commit, want 0", dout_val);
    end
    rx_idle(1);
    tests++;
    if (dout_val !== 1'b1 || dout_sop !== 1'b1) begin
      fails++;
      $display("FAIL lat_first: val=%b sop=%b two edges after commit, want 1 1", dout_val, dout_sop);
    end
    for (int i = 0; i < 3; i++) begin
      rx_idle(1);
      tests++;
      if (dout_val !== 1'b1) begin
        fails++;
        $display("FAIL lat_stream: word %0d val=%b, want 1", i + 1, dout_val);
      end
    end
    rx_idle(1);
    tests++;
    if (dout_val !== 1'b0 || pkt_cnt !== 10'd0) begin
      fails++;
      $display("FAIL lat_end: val=%b pkt_cnt=%0d, want 0 and 0", dout_val, pkt_cnt);
    end
  endtask

  task automatic test_single_word;
    int n;
    dout_rdy = 1'b1;
    sb.push_back({1'b1, 1'b1, 1'b1, 64'h5151_0000_CAFE_0001});
    rx_word(1'b1, 1'b1, 1'b1, 64'h5151_0000_CAFE_0001);
    n = 0;
    while (dout_val !== 1'b1 && n < 8) begin rx_idle(1); n++; end
    tests++;
    if ({dout_val, dout_sop, dout_eop, dout_dwen} !== 4'hF || dout !== 64'h5151_0000_CAFE_0001) begin
      fails++;
      $display("FAIL single_word: val/sop/eop/dwen=%b%b%b%b dout=%h, want 1111 5151_0000_cafe_0001",
               dout_val, dout_sop, dout_eop, dout_dwen, dout);
    end
    drain(20);
  endtask

  task automatic test_full_drop;
    int d0, p0;
    dout_rdy = 1'b0;
    rx_idle(2);
    d0 = int'(drop_cnt);
    p0 = pulse_cnt;
    for (int p = 0; p < 51; p++) send_pkt(10, 64'hF000_0000_0000_0000 | (64'(p) << 16), 1'b1);
    send_pkt(4, 64'hDEAD_0000_0000_0000, 1'b0);
    rx_idle(2);
    tests++;
    if (int'(drop_cnt) != d0 + 1 || pulse_cnt != p0 + 1 || pkt_cnt !== 10'd51) begin
      fails++;
      $display("FAIL full_drop: drop_cnt=%0d pulses=%0d pkt_cnt=%0d, want %0d %0d 51",
               drop_cnt, pulse_cnt - p0, pkt_cnt, d0 + 1, 1);
    end
    dout_rdy = 1'b1;
    drain(700);
    tests++;
    if (pkt_cnt !== 10'd0) begin
      fails++;
      $display("FAIL full_pktcnt: pkt_cnt=%0d after drain, want 0", pkt_cnt);
    end
  endtask

  task automatic test_missing_end;
    int d0;
    dout_rdy = 1'b1;
    d0 = int'(drop_cnt);
    rx_word(1'b1, 1'b0, 1'b0, 64'hBAD0_0000_0000_0000);
    rx_word(1'b0, 1'b0, 1'b0, 64'hBAD0_0000_0000_0001);
    sb.push_back({1'b0, 1'b1, 1'b0, 64'hC0DE_0000_0000_0000});
    rx_word(1'b1, 1'b0, 1'b0, 64'hC0DE_0000_0000_0000);
    tests++;
    if (drop_pulse !== 1'b1 || int'(drop_cnt) != d0 + 1) begin
      fails++;
      $display("FAIL restart_drop: pulse=%b drop_cnt=%0d, want 1 and %0d", drop_pulse, drop_cnt, d0 + 1);
    end
    sb.push_back({1'b0, 1'b0, 1'b0, 64'hC0DE_0000_0000_0001});
    rx_word(1'b0, 1'b0, 1'b0, 64'hC0DE_0000_0000_0001);
    sb.push_back({1'b1, 1'b0, 1'b1, 64'hC0DE_0000_0000_0002});
    rx_word(1'b0, 1'b1, 1'b1, 64'hC0DE_0000_0000_0002);
    drain(20);
  endtask

  task automatic test_back_to_back;
    logic stop_rand;
    stop_rand = 1'b0;
    fork
      begin
        for (int p = 0; p < 6; p++) send_pkt(8, 64'hB2B0_0000_0000_0000 | (64'(p) << 8), 1'b1);
        stop_rand = 1'b1;
      end
      begin
        while (!stop_rand) begin
          dout_rdy = 1'($urandom_range(0, 1));
          @(posedge clk_125); #2;
        end
      end
    join
    dout_rdy = 1'b1;
    drain(200);
    tests++;
    if (pkt_cnt !== 10'd0) begin
      fails++;
      $display("FAIL b2b_pktcnt: pkt_cnt=%0d, want 0", pkt_cnt);
    end
  endtask

  task automatic test_reset_mid;
    dout_rdy = 1'b0;
    send_pkt(8, 64'h7700_0000_0000_0000, 1'b1);
    dout_rdy = 1'b1;
    rx_word(1'b1, 1'b0, 1'b0, 64'h7800_0000_0000_0000);
    rx_word(1'b0, 1'b0, 1'b0, 64'h7800_0000_0000_0001);
    rx_word(1'b0, 1'b0, 1'b0, 64'h7800_0000_0000_0002);
    rx_val = 1'b1; rx_data = 64'h7800_0000_0000_0003;
    rstn = 1'b0;
    @(posedge clk_125); #2;
    rx_val = 1'b0;
    sb.delete();
    tests++;
    if ({dout_val, dout_sop, dout_eop, dout_dwen, dout, pkt_cnt, drop_cnt, drop_pulse} !== '0) begin
      fails++;
      $display("FAIL reset_mid: val=%b dout=%h pkt=%0d drop=%0d pulse=%b, want all 0",
               dout_val, dout, pkt_cnt, drop_cnt, drop_pulse);
    end
    rstn = 1'b1;
    rx_idle(1);
    send_pkt(3, 64'h9900_0000_0000_0000, 1'b1);
    drain(20);
    tests++;
    if (pkt_cnt !== 10'd0 || drop_cnt !== 16'd0) begin
      fails++;
      $display("FAIL post_reset: pkt_cnt=%0d drop_cnt=%0d, want 0 0", pkt_cnt, drop_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_single_word();
    test_full_drop();
    test_missing_end();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
